pipe_mem_arbiter: RTL
=====================

PIPE_MEM_ARBITER -- requirements
Module: pipe_mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_MEM_RUN, default 3, meaning max consecutive MEM grants while IF waits (range 1..15).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port clrn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port if_req  input  1  IF stage fetch request, held until if_ready.
REQ-005 SHALL have port if_addr  input  32  fetch byte address (pc).
REQ-006 SHALL have port if_rdata  output  32  fetched instruction, registered.
REQ-007 SHALL have port if_ready  output  1  one-cycle pulse, if_rdata valid.
REQ-008 SHALL have port mem_req  input  1  MEM stage data request, held until mem_ready.
REQ-009 SHALL have port mem_we  input  1  1 = store, 0 = load.
REQ-010 SHALL have ports mem_addr, mem_wdata  input  32 each  data address and store data.
REQ-011 SHALL have port mem_rdata  output  32  load data, registered.
REQ-012 SHALL have port mem_ready  output  1  one-cycle pulse, access complete.
REQ-013 SHALL have ports ram_en, ram_we  output  1 each  single-port RAM strobe and write enable.
REQ-014 SHALL have ports ram_addr, ram_wdata  output  32 each  RAM address and write data.
REQ-015 SHALL have ports ram_rdata  input  32, ram_ack  input  1  RAM read data and completion (variable wait, >=0 cycles).

Function
REQ-016 SHALL implement FSM states IDLE, SERVE_IF, SERVE_MEM.
REQ-017 IDLE: no request -> stay; only one request -> grant it; both -> grant MEM unless mem_run == MAX_MEM_RUN, then grant IF.
REQ-018 On grant SHALL latch addr/we/wdata of the winner; ram_* driven from latched copy only.
REQ-019 In SERVE_x ram_en SHALL be 1, ram_we = latched we (0 for IF), until ram_ack.
REQ-020 On ram_ack in SERVE_x: capture ram_rdata into x_rdata, pulse x_ready next cycle, return to IDLE.
REQ-021 Minimum latency: req in IDLE cycle t, zero-wait RAM -> ready at t+2; each RAM wait cycle adds one.
REQ-022 MEM store SHALL leave mem_rdata unchanged; mem_ready still pulses.
REQ-023 mem_run (4-bit) SHALL increment on each MEM grant made while if_req=1, clear on any IF grant, saturate at MAX_MEM_RUN.
REQ-024 Requester dropping req during service SHALL NOT abort; access completes, ready still pulses.
REQ-025 Requester re-asserting req in cycle of its ready pulse SHALL be treated as a new request.
REQ-026 ram_ack outside SERVE_x SHALL be ignored.
REQ-027 if_ready and mem_ready SHALL never be 1 in the same cycle.

Reset
REQ-028 clrn=0 SHALL immediately force IDLE, mem_run=0, ram_en=0, ram_we=0, if_ready=0, mem_ready=0, ram_addr/ram_wdata/if_rdata/mem_rdata=0.
REQ-029 Reset mid-access SHALL abandon the transaction without a ready pulse; first grant possible on first edge after clrn rises.

Structure
REQ-030 State encoding and MAX_MEM_RUN default SHALL live in shared package pipe_pkg.
REQ-031 Single module; no sub-module; FSM, latches and counter in one file.

Verification
REQ-032 if_req only, if_addr=0x0000_0004, ram zero-wait, ram_rdata=0x2001_0005 -> if_ready at t+2, if_rdata=0x2001_0005, ram_we=0.
REQ-033 Both req at t, mem_we=1, mem_addr=0x10, mem_wdata=0xDEAD_BEEF -> MEM served first (ram_we=1, ram_addr=0x10), IF served next; mem_rdata unchanged.
REQ-034 Continuous MEM and IF requests, MAX_MEM_RUN=3 -> grant order MEM,MEM,MEM,IF repeating.
REQ-035 RAM ack delayed 4 cycles on MEM load -> ram_en held 5 cycles, ram_addr stable, mem_ready at t+6.
REQ-036 clrn low during SERVE_MEM -> ram_en=0 same cycle, no mem_ready, after release pending IF granted normally.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline memory arbiter: FSM state encoding
// and the default limit on back-to-back MEM grants while IF is waiting.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SERVE_IF  = 2'd1,
    SERVE_MEM = 2'd2
  } arb_state_e;

  localparam int unsigned MAX_MEM_RUN_DEFAULT = 3;

endpackage

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates a single-port RAM between the IF (fetch) and MEM (load/store) stages.
// MEM has priority, but only for MAX_MEM_RUN consecutive grants while IF waits.
module pipe_mem_arbiter
  import pipe_pkg::*;
#(
  parameter int unsigned MAX_MEM_RUN = MAX_MEM_RUN_DEFAULT
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        ram_en,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack
);

  localparam logic [3:0] RUN_LIMIT = 4'(MAX_MEM_RUN);

  arb_state_e  state_q;
  logic [3:0]  mem_run_q;
  logic [3:0]  mem_run_d;
  logic        ram_en_q;
  logic        ram_we_q;
  logic [31:0] ram_addr_q;
  logic [31:0] ram_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] mem_rdata_q;
  logic        if_ready_q;
  logic        mem_ready_q;
  logic        grant_if;
  logic        grant_mem;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    mem_run_d = mem_run_q;
    if (state_q == IDLE) begin
      if (mem_req && !(if_req && mem_run_q == RUN_LIMIT)) begin
        grant_mem = 1'b1;
      end else if (if_req) begin
        grant_if = 1'b1;
      end
    end
    if (grant_if) begin
      mem_run_d = '0;
    end else if (grant_mem && if_req && mem_run_q != RUN_LIMIT) begin
      mem_run_d = mem_run_q + 4'd1;
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update together on the edge.
  // NOTE: data registers are reset too, because the outputs they drive must read zero in reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      mem_run_q   <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_run_q   <= mem_run_d;
      unique case (state_q)
        IDLE: begin
          if (grant_mem) begin
            state_q     <= SERVE_MEM;
            ram_en_q    <= 1'b1;
            ram_we_q    <= mem_we;
            ram_addr_q  <= mem_addr;
            ram_wdata_q <= mem_wdata;
          end else if (grant_if) begin
            state_q     <= SERVE_IF;
            ram_en_q    <= 1'b1;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= if_addr;
            ram_wdata_q <= '0;
          end
        end
        SERVE_IF: begin
          if (ram_ack) begin
            state_q    <= IDLE;
            ram_en_q   <= 1'b0;
            if_rdata_q <= ram_rdata;
            if_ready_q <= 1'b1;
          end
        end
        SERVE_MEM: begin
          if (ram_ack) begin
            state_q  <= IDLE;
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            // A store completes the handshake but must not disturb the last load result.
            if (!ram_we_q) begin
              mem_rdata_q <= ram_rdata;
            end
            mem_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          ram_en_q <= 1'b0;
          ram_we_q <= 1'b0;
        end
      endcase
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ready  = if_ready_q;
  assign mem_ready = mem_ready_q;

endmodule
